// File: rtl/ip_call_stack.sv
// Instruction pointer with increment, signed relative branch and a return-address stack.
// Define IP_PREV_EN to add ip_prev, the IP held before the last executed jump/call/ret/rel.
module ip_call_stack #(
  parameter int unsigned        ADDR_W       = 16,
  parameter logic [ADDR_W-1:0]  INC_STEP     = ADDR_W'(1),
  parameter int unsigned        STACK_DEPTH  = 8,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            load_ip,
  input  logic                            inc_ip,
  input  logic                            rel_ip,
  input  logic                            call_ip,
  input  logic                            ret_ip,
  input  logic                            clr_err,
  input  logic [ADDR_W-1:0]               ip_data_in,
  input  logic [ADDR_W-1:0]               ip_offset,
  output logic [ADDR_W-1:0]               ip_data_out,
  output logic [$clog2(STACK_DEPTH):0]    stack_count,
  output logic                            stack_full,
  output logic                            stack_empty,
  output logic                            err_overflow,
  output logic                            err_underflow
`ifdef IP_PREV_EN
  ,
  output logic [ADDR_W-1:0]               ip_prev
`endif
);

  localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic [ADDR_W-1:0] ip_d;
  logic [ADDR_W-1:0] ret_addr;
  logic [CNT_W-1:0]  cnt_d;
  logic [PTR_W-1:0]  wr_idx;
  logic [PTR_W-1:0]  rd_idx;
  logic              push;
  logic              ov_set;
  logic              un_set;

  assign stack_full  = (stack_count == CNT_W'(STACK_DEPTH));
  assign stack_empty = (stack_count == '0);
  assign ret_addr    = ip_data_out + INC_STEP;
  assign wr_idx      = PTR_W'(stack_count);
  assign rd_idx      = PTR_W'(stack_count - CNT_W'(1));

  // Strobe priority: load > call > ret > rel > inc; dropped call/ret only raise a flag.
  always_comb begin
    ip_d   = ip_data_out;
    cnt_d  = stack_count;
    push   = 1'b0;
    ov_set = 1'b0;
    un_set = 1'b0;
    if (load_ip) begin
      ip_d = ip_data_in;
    end else if (call_ip) begin
      if (stack_full) begin
        ov_set = 1'b1;
      end else begin
        push  = 1'b1;
        cnt_d = stack_count + CNT_W'(1);
        ip_d  = ip_data_in;
      end
    end else if (ret_ip) begin
      if (stack_empty) begin
        un_set = 1'b1;
      end else begin
        cnt_d = stack_count - CNT_W'(1);
        ip_d  = stack_mem[rd_idx];
      end
    end else if (rel_ip) begin
      ip_d = ip_data_out + ip_offset;
    end else if (inc_ip) begin
      ip_d = ip_data_out + INC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ip_data_out   <= RESET_VECTOR;
      stack_count   <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      ip_data_out   <= ip_d;
      stack_count   <= cnt_d;
      err_overflow  <= ov_set | (err_overflow & ~clr_err);
      err_underflow <= un_set | (err_underflow & ~clr_err);
    end
  end

  // Contents need no reset; a reset edge still must not push.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      stack_mem[wr_idx] <= ret_addr;
    end
  end

`ifdef IP_PREV_EN
  logic upd_prev;

  assign upd_prev = load_ip | push |
                    (!call_ip & ((ret_ip & !stack_empty) | (!ret_ip & rel_ip)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      ip_prev <= RESET_VECTOR;
    end else if (upd_prev) begin
      ip_prev <= ip_data_out;
    end
  end
`else
  // No trace register in this build.
`endif

endmodule

// File: tb/tb_ip_call_stack.sv
// Directed bench for ip_call_stack: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_ip_call_stack;

  logic        clk;
  logic        reset;
  logic        load_ip, inc_ip, rel_ip, call_ip, ret_ip, clr_err;
  logic [15:0] ip_data_in, ip_offset;
  logic [15:0] ip_data_out;
  logic [3:0]  stack_count;
  logic        stack_full, stack_empty, err_overflow, err_underflow;
`ifdef IP_PREV_EN
  logic [15:0] ip_prev;
`endif

  ip_call_stack dut (
    .clk           (clk),
    .reset         (reset),
    .load_ip       (load_ip),
    .inc_ip        (inc_ip),
    .rel_ip        (rel_ip),
    .call_ip       (call_ip),
    .ret_ip        (ret_ip),
    .clr_err       (clr_err),
    .ip_data_in    (ip_data_in),
    .ip_offset     (ip_offset),
    .ip_data_out   (ip_data_out),
    .stack_count   (stack_count),
    .stack_full    (stack_full),
    .stack_empty   (stack_empty),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
`ifdef IP_PREV_EN
    ,
    .ip_prev       (ip_prev)
`endif
  );

  typedef struct {
    string       name;
    logic [15:0] ip;
    logic [3:0]  cnt;
    logic        ov;
    logic        un;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.name, "ip",    ip_data_out,           e.ip);
      check(e.name, "count", {12'd0, stack_count},  {12'd0, e.cnt});
      check(e.name, "full",  {15'd0, stack_full},   {15'd0, (e.cnt == 4'd8)});
      check(e.name, "empty", {15'd0, stack_empty},  {15'd0, (e.cnt == 4'd0)});
      check(e.name, "ovf",   {15'd0, err_overflow}, {15'd0, e.ov});
      check(e.name, "unf",   {15'd0, err_underflow},{15'd0, e.un});
    end
  end

  // cmd bits: {rst_n, load, call, ret, rel, inc, clr}
  task automatic step(input string nm, input logic [6:0] cmd,
                      input logic [15:0] din, input logic [15:0] off,
                      input logic [15:0] eip, input logic [3:0] ecnt,
                      input logic eov, input logic eun);
    exp_t e;
    {reset, load_ip, call_ip, ret_ip, rel_ip, inc_ip, clr_err} = cmd;
    ip_data_in = din;
    ip_offset  = off;
    @(posedge clk);
    #1;
    {load_ip, call_ip, ret_ip, rel_ip, inc_ip, clr_err} = '0;
    e.name = nm; e.ip = eip; e.cnt = ecnt; e.ov = eov; e.un = eun;
    sb.push_back(e);
  endtask

  localparam logic [6:0] C_RST  = 7'b0000000;
  localparam logic [6:0] C_IDLE = 7'b1000000;
  localparam logic [6:0] C_LOAD = 7'b1100000;
  localparam logic [6:0] C_CALL = 7'b1010000;
  localparam logic [6:0] C_RET  = 7'b1001000;
  localparam logic [6:0] C_REL  = 7'b1000100;
  localparam logic [6:0] C_INC  = 7'b1000010;
  localparam logic [6:0] C_CLR  = 7'b1000001;

  initial begin
    {load_ip, call_ip, ret_ip, rel_ip, inc_ip, clr_err} = '0;
    reset = 1'b0;
    ip_data_in = '0;
    ip_offset  = '0;

    step("rst0", C_RST, 16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);
    step("rst1", C_RST, 16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);
    step("ld1000", C_LOAD, 16'h1000, 16'h0000, 16'h1000, 4'd0, 1'b0, 1'b0);
    step("inc_a", C_INC, 16'h0000, 16'h0000, 16'h1001, 4'd0, 1'b0, 1'b0);
    step("inc_b", C_INC, 16'h0000, 16'h0000, 16'h1002, 4'd0, 1'b0, 1'b0);

    step("ld2000", C_LOAD, 16'h2000, 16'h0000, 16'h2000, 4'd0, 1'b0, 1'b0);
    step("call3000", C_CALL, 16'h3000, 16'h0000, 16'h3000, 4'd1, 1'b0, 1'b0);
    step("call4000", C_CALL, 16'h4000, 16'h0000, 16'h4000, 4'd2, 1'b0, 1'b0);
    step("ret_a", C_RET, 16'h0000, 16'h0000, 16'h3001, 4'd1, 1'b0, 1'b0);
    step("ret_b", C_RET, 16'h0000, 16'h0000, 16'h2001, 4'd0, 1'b0, 1'b0);

    step("ld0002", C_LOAD, 16'h0002, 16'h0000, 16'h0002, 4'd0, 1'b0, 1'b0);
    step("rel_m4", C_REL, 16'h0000, 16'hFFFC, 16'hFFFE, 4'd0, 1'b0, 1'b0);
    step("inc_w1", C_INC, 16'h0000, 16'h0000, 16'hFFFF, 4'd0, 1'b0, 1'b0);
    step("inc_w2", C_INC, 16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);
    step("idle", C_IDLE, 16'h1234, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);

    // Fill: call i targets i*1000, return address pushed is previous IP + 1.
    step("ld0100", C_LOAD, 16'h0100, 16'h0000, 16'h0100, 4'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++)
      step($sformatf("fill%0d", i), C_CALL, 16'(i * 16'h1000), 16'h0000,
           16'(i * 16'h1000), 4'(i), 1'b0, 1'b0);
    step("call_ovf", C_CALL, 16'h9000, 16'h0000, 16'h8000, 4'd8, 1'b1, 1'b0);
    for (int k = 1; k <= 7; k++)
      step($sformatf("drain%0d", k), C_RET, 16'h0000, 16'h0000,
           16'((8 - k) * 16'h1000 + 1), 4'(8 - k), 1'b1, 1'b0);
    step("drain8", C_RET, 16'h0000, 16'h0000, 16'h0101, 4'd0, 1'b1, 1'b0);
    step("ret_unf", C_RET, 16'h0000, 16'h0000, 16'h0101, 4'd0, 1'b1, 1'b1);
    step("ret_inc_unf", 7'b1001010, 16'h0000, 16'h0000, 16'h0101, 4'd0, 1'b1, 1'b1);
    step("clr", C_CLR, 16'h0000, 16'h0000, 16'h0101, 4'd0, 1'b0, 1'b0);
    step("clr_vs_set", 7'b1001001, 16'h0000, 16'h0000, 16'h0101, 4'd0, 1'b0, 1'b1);
    step("clr2", C_CLR, 16'h0000, 16'h0000, 16'h0101, 4'd0, 1'b0, 1'b0);

    step("prio_ld", 7'b1110010, 16'h5555, 16'h0000, 16'h5555, 4'd0, 1'b0, 1'b0);
    step("prio_call", 7'b1011100, 16'h7777, 16'h0010, 16'h7777, 4'd1, 1'b0, 1'b0);
    step("prio_rel", 7'b1000110, 16'h0000, 16'h0010, 16'h7787, 4'd1, 1'b0, 1'b0);
    step("ret_5556", C_RET, 16'h0000, 16'h0000, 16'h5556, 4'd0, 1'b0, 1'b0);

    step("callA", C_CALL, 16'hA000, 16'h0000, 16'hA000, 4'd1, 1'b0, 1'b0);
    step("callB", C_CALL, 16'hB000, 16'h0000, 16'hB000, 4'd2, 1'b0, 1'b0);
    step("callC", C_CALL, 16'hC000, 16'h0000, 16'hC000, 4'd3, 1'b0, 1'b0);
    step("rst_call", 7'b0010000, 16'hD000, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);
`ifdef IP_PREV_EN
    check("rst_call", "prev", ip_prev, 16'h0000);
`endif
    step("ret_after_rst", C_RET, 16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b1);

    for (int n = 0; n < 20 && sb.size() > 0; n++) @(negedge clk);
    #1;
    check("drain", "queue_left", 16'(sb.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
